// File: rtl/rr_bus_arbiter_pkg.sv
// Shared arbiter definitions: FSM state encoding and index-width helper.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    PARK  = 2'b10
  } arb_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between the masters and the bus arbiter.
interface rr_bus_arbiter_if import arb_pkg::*; #(
  parameter int N = 4
) ();

  localparam int IW = idx_width(N);

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          gnt_valid;
  logic          timeout;

  modport master (output req, input gnt, input gnt_id, input gnt_valid, input timeout);
  modport slave  (input req, output gnt, output gnt_id, output gnt_valid, output timeout);

endinterface

// File: rtl/rr_pick.sv
// Combinational winner search: rotating scan after last_owner, or lowest index first.
module rr_pick import arb_pkg::*; #(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_owner,
  input  logic          mode,
  output logic          found,
  output logic [IW-1:0] winner
);

  logic [IW-1:0] idx_s;

  // First set request in scan order; the scan start depends on mode.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx_s  = '0;
    for (int i = 0; i < N; i++) begin
      if (mode) begin
        idx_s = IW'((int'(last_owner) + 1 + i) % N);
      end else begin
        idx_s = IW'(i);
      end
      if (!found && req[idx_s]) begin
        found  = 1'b1;
        winner = idx_s;
      end else begin
        found  = found;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// N-master bus arbiter with tenure limit and a forced one-cycle park gap between owners.
module rr_bus_arbiter import arb_pkg::*; #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int RR_MODE  = 1
) (
  input  logic            clk,
  input  logic            rst,
  rr_bus_arbiter_if.slave bus
);

  localparam int            IW       = idx_width(N);
  localparam int            HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
  localparam logic          MODE_RR  = (RR_MODE != 0);

  arb_state_e    state_r, state_s;
  logic [N-1:0]  gnt_r, gnt_s;
  logic [IW-1:0] gnt_id_r, gnt_id_s;
  logic          gnt_valid_r, gnt_valid_s;
  logic          timeout_r, timeout_s;
  logic [HW-1:0] hold_cnt_r, hold_cnt_s;
  logic [IW-1:0] last_owner_r, last_owner_s;
  logic          found_s;
  logic [IW-1:0] winner_s;
  logic          owner_req_s;
  logic          others_s;

  rr_pick #(.N(N)) u_pick (
    .req        (bus.req),
    .last_owner (last_owner_r),
    .mode       (MODE_RR),
    .found      (found_s),
    .winner     (winner_s)
  );

  assign owner_req_s = bus.req[gnt_id_r];
  assign others_s    = |(bus.req & ~gnt_r);

  // Next-state and next-output logic; PARK arbitrates exactly like IDLE.
  always_comb begin
    state_s      = state_r;
    gnt_s        = gnt_r;
    gnt_id_s     = gnt_id_r;
    timeout_s    = 1'b0;
    hold_cnt_s   = hold_cnt_r;
    last_owner_s = last_owner_r;
    case (state_r)
      IDLE, PARK: begin
        if (found_s) begin
          state_s    = GRANT;
          gnt_s      = N'(1) << winner_s;
          gnt_id_s   = winner_s;
          hold_cnt_s = HW'(1);
        end else begin
          state_s    = IDLE;
          gnt_s      = '0;
          hold_cnt_s = '0;
        end
      end
      GRANT: begin
        if (!owner_req_s) begin
          state_s      = PARK;
          gnt_s        = '0;
          hold_cnt_s   = '0;
          last_owner_s = gnt_id_r;
        end else if ((hold_cnt_r == HOLD_MAX) && others_s) begin
          state_s      = PARK;
          gnt_s        = '0;
          hold_cnt_s   = '0;
          last_owner_s = gnt_id_r;
          timeout_s    = 1'b1;
        end else begin
          state_s = GRANT;
          // Saturate so a lone holder never wraps the tenure count.
          if (hold_cnt_r < HOLD_MAX) begin
            hold_cnt_s = hold_cnt_r + HW'(1);
          end else begin
            hold_cnt_s = HOLD_MAX;
          end
        end
      end
      default: begin
        state_s    = IDLE;
        gnt_s      = '0;
        hold_cnt_s = '0;
      end
    endcase
    gnt_valid_s = |gnt_s;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      gnt_r        <= '0;
      gnt_id_r     <= '0;
      gnt_valid_r  <= 1'b0;
      timeout_r    <= 1'b0;
      hold_cnt_r   <= '0;
      last_owner_r <= LAST_RST;
    end else begin
      state_r      <= state_s;
      gnt_r        <= gnt_s;
      gnt_id_r     <= gnt_id_s;
      gnt_valid_r  <= gnt_valid_s;
      timeout_r    <= timeout_s;
      hold_cnt_r   <= hold_cnt_s;
      last_owner_r <= last_owner_s;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_id    = gnt_id_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Randomised and directed checks of a round-robin and a fixed-priority arbiter against a reference model.
module tb_rr_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req_v = 4'b0000;

  int vectors     = 0;
  int miscompares = 0;

  // Model: index 0 is the round-robin instance, index 1 the fixed-priority one.
  int m_owner[2];
  int m_ten[2];
  int m_last[2];
  bit m_to[2];

  always #5 clk = ~clk;

  rr_bus_arbiter_if #(.N(N)) rr_if ();
  rr_bus_arbiter_if #(.N(N)) fp_if ();

  rr_bus_arbiter #(.N(N), .MAX_HOLD(MH), .RR_MODE(1)) u_rr (.clk(clk), .rst(rst), .bus(rr_if.slave));
  rr_bus_arbiter #(.N(N), .MAX_HOLD(MH), .RR_MODE(0)) u_fp (.clk(clk), .rst(rst), .bus(fp_if.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last, input bit rr);
    int i;
    for (int k = 0; k < N; k++) begin
      i = rr ? (last + 1 + k) % N : k;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_ten[k]   = 0;
      m_last[k]  = N - 1;
      m_to[k]    = 1'b0;
    end
  endtask

  // One clock edge of the reference: an owner leaves for one empty cycle, else the free bus is awarded.
  task automatic model_step(input logic [3:0] r);
    int w;
    for (int k = 0; k < 2; k++) begin
      m_to[k] = 1'b0;
      if (m_owner[k] >= 0) begin
        if (!r[m_owner[k]]) begin
          m_last[k]  = m_owner[k];
          m_owner[k] = -1;
        end else if (m_ten[k] >= MH && (r & ~(4'b0001 << m_owner[k])) != 4'b0000) begin
          m_last[k]  = m_owner[k];
          m_owner[k] = -1;
          m_to[k]    = 1'b1;
        end else begin
          m_ten[k]++;
        end
      end else begin
        w = pick(r, m_last[k], k == 0);
        if (w >= 0) begin
          m_owner[k] = w;
          m_ten[k]   = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] og, eg;
    logic [1:0] oid;
    logic       ov, ot;
    string      p;
    for (int k = 0; k < 2; k++) begin
      p   = (k == 0) ? "rr" : "fp";
      og  = (k == 0) ? rr_if.gnt : fp_if.gnt;
      oid = (k == 0) ? rr_if.gnt_id : fp_if.gnt_id;
      ov  = (k == 0) ? rr_if.gnt_valid : fp_if.gnt_valid;
      ot  = (k == 0) ? rr_if.timeout : fp_if.timeout;
      eg  = (m_owner[k] >= 0) ? 4'(4'b0001 << m_owner[k]) : 4'b0000;
      chk({p, "_gnt"}, 32'(og), 32'(eg));
      chk({p, "_valid"}, 32'(ov), 32'(m_owner[k] >= 0));
      chk({p, "_timeout"}, 32'(ot), 32'(m_to[k]));
      if (m_owner[k] >= 0) chk({p, "_gnt_id"}, 32'(oid), 32'(m_owner[k]));
    end
  endtask

  task automatic set_req(input logic [3:0] v);
    req_v     = v;
    rr_if.req = v;
    fp_if.req = v;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step(req_v);
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         order[$];
    int         exp_order[5] = '{0, 1, 2, 3, 0};
    int         exp_g[11]    = '{1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 1};
    int         exp_t[11]    = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    bit         prev_valid;
    bit         seen;
    logic [3:0] v;

    model_reset();
    set_req(4'b0000);
    rst = 1'b0;
    tick();
    tick();
    chk("reset_gnt", 32'(rr_if.gnt), 32'h0);
    rst = 1'b1;

    // First grant one cycle after the request, then asynchronous reset mid-tenure.
    set_req(4'b0100);
    tick();
    chk("first_gnt", 32'(rr_if.gnt), 32'h4);
    chk("first_id", 32'(rr_if.gnt_id), 32'h2);
    tick();
    rst = 1'b0;
    #2;
    model_reset();
    chk("async_rst_rr", 32'(rr_if.gnt), 32'h0);
    chk("async_rst_fp", 32'(fp_if.gnt), 32'h0);
    tick();
    rst = 1'b1;

    // Rotation: every owner releases after two grant cycles.
    set_req(4'b1111);
    prev_valid = 1'b0;
    for (int i = 0; i < 40 && order.size() < 5; i++) begin
      tick();
      if (rr_if.gnt_valid && !prev_valid) order.push_back(int'(rr_if.gnt_id));
      prev_valid = rr_if.gnt_valid;
      if (m_owner[0] >= 0 && m_ten[0] == 2) set_req(4'b1111 & ~(4'b0001 << m_owner[0]));
      else set_req(4'b1111);
    end
    chk("rot_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("rot_order", 32'(order[i]), 32'(exp_order[i]));
    set_req(4'b0000);
    repeat (3) tick();

    // Tenure timeout alternation between masters 0 and 1.
    do_reset();
    set_req(4'b0011);
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("to_gnt", 32'(rr_if.gnt), 32'(exp_g[i]));
      chk("to_pulse", 32'(rr_if.timeout), 32'(exp_t[i]));
    end

    // A lone requester keeps the bus without timing out.
    do_reset();
    set_req(4'b0010);
    seen = 1'b0;
    repeat (20) begin
      tick();
      chk("lone_gnt", 32'(rr_if.gnt), 32'h2);
      seen = seen | rr_if.timeout;
    end
    chk("lone_timeout", 32'(seen), 32'h0);

    // Fixed priority: lowest index always wins.
    do_reset();
    set_req(4'b0100);
    tick();
    chk("fp_own2", 32'(fp_if.gnt), 32'h4);
    set_req(4'b1001);
    tick();
    chk("fp_park", 32'(fp_if.gnt), 32'h0);
    tick();
    chk("fp_lowest", 32'(fp_if.gnt), 32'h1);
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen = seen | fp_if.gnt[3];
    end
    chk("fp_no_m3", 32'(seen), 32'h0);

    // Wrap from owner 3, with a request that only rises during the park cycle.
    do_reset();
    set_req(4'b1000);
    tick();
    chk("wrap_own3", 32'(rr_if.gnt), 32'h8);
    set_req(4'b0000);
    tick();
    chk("wrap_park", 32'(rr_if.gnt), 32'h0);
    set_req(4'b0010);
    tick();
    chk("wrap_late", 32'(rr_if.gnt), 32'h2);
    set_req(4'b0000);
    tick();
    tick();
    chk("wrap_idle", 32'(rr_if.gnt), 32'h0);

    // Random request traffic with occasional asynchronous resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v = req_v;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) v[b] = ~v[b];
      end
      set_req(v);
      if ($urandom_range(399) == 0) begin
        rst = 1'b0;
        #2;
        model_reset();
        chk("rand_rst_rr", 32'(rr_if.gnt), 32'h0);
        chk("rand_rst_fp", 32'(fp_if.gnt), 32'h0);
        tick();
        rst = 1'b1;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
